// File: rtl/global_command_sequencer_pkg.sv
// Shared command codes and sequencer state encoding. The global command decoder
// decodes the same CMD_* values.
package global_command_defs;

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_INC_NONCE = 3'd1;
    localparam logic [2:0] CMD_SAVE_BEST = 3'd2;
    localparam logic [2:0] CMD_TRANSMIT  = 3'd3;
    localparam logic [2:0] CMD_CONST_OE  = 3'd4;
    localparam logic [2:0] CMD_NONCE_OE  = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CONST,
        ST_LOAD_NONCE,
        ST_START,
        ST_WAIT_HASH,
        ST_SAVE,
        ST_INCREMENT,
        ST_TX_WAIT,
        ST_TRANSMIT
    } seq_state_e;

endpackage

// File: rtl/global_command_sequencer_interval_counter.sv
// Modulo-WRAP event counter. wrap_o flags the increment that returns the count to zero.
module sequencer_interval_counter #(
    parameter int unsigned WRAP = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic wrap_o
);

    localparam int unsigned W = $clog2(WRAP + 1);
    localparam logic [W-1:0] LAST = W'(WRAP - 1);

    logic [W-1:0] count;

    assign wrap_o = inc_i && (count == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count <= '0;
        end else if (inc_i) begin
            count <= wrap_o ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/global_command_sequencer.sv
// Per-nonce command sequencer driving the global command bus; issues a transmit
// every TRANSMIT_INTERVAL nonces or when the host asks for one.
//
// state       | meaning
// IDLE        | stopped, waiting for enable_i
// LOAD_CONST  | constants ROM on the bus for LOAD_CYCLES cycles
// LOAD_NONCE  | nonce module on the bus for LOAD_CYCLES cycles
// START       | one-cycle start pulse to the Skein core
// WAIT_HASH   | waiting for hash_done_i
// SAVE        | save best hash if the comparator reported a better one
// INCREMENT   | advance the nonce and the completed-nonce count
// TX_WAIT     | transmit pending, waiting for the transmitter to go idle
// TRANSMIT    | one-cycle transmit command
module global_command_sequencer
    import global_command_defs::*;
#(
    parameter int unsigned LOAD_CYCLES       = 4,
    parameter int unsigned TRANSMIT_INTERVAL = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        hash_done_i,
    input  logic        better_i,
    input  logic        transmit_req_i,
    input  logic        tx_busy_i,
    output logic        hash_start_o,
    output logic [2:0]  global_command_o,
    output logic        busy_o,
    output logic [31:0] hash_count_o
);

    seq_state_e state;
    seq_state_e next_state;
    logic [2:0] cmd_next;
    logic       load_active;
    logic       load_wrap;
    logic       entering_increment;
    logic       interval_wrap;
    logic       tx_due;
    logic       tx_latch;

    assign load_active        = (state == ST_LOAD_CONST) || (state == ST_LOAD_NONCE);
    assign entering_increment = (next_state == ST_INCREMENT);

    // Restarts from zero on every load-state change, so each load phase is LOAD_CYCLES long.
    sequencer_interval_counter #(
        .WRAP (LOAD_CYCLES)
    ) u_load_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (~load_active),
        .inc_i  (load_active),
        .wrap_o (load_wrap)
    );

    sequencer_interval_counter #(
        .WRAP (TRANSMIT_INTERVAL)
    ) u_tx_interval (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (1'b0),
        .inc_i  (entering_increment),
        .wrap_o (interval_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_next   = CMD_NOP;
        unique case (state)
            ST_IDLE:       if (enable_i) next_state = ST_LOAD_CONST;
            ST_LOAD_CONST: if (load_wrap) next_state = ST_LOAD_NONCE;
            ST_LOAD_NONCE: if (load_wrap) next_state = ST_START;
            ST_START:      next_state = ST_WAIT_HASH;
            ST_WAIT_HASH:  if (hash_done_i) next_state = ST_SAVE;
            ST_SAVE:       next_state = ST_INCREMENT;
            ST_INCREMENT: begin
                if (tx_due || tx_latch) begin
                    next_state = ST_TX_WAIT;
                end else if (enable_i) begin
                    next_state = ST_LOAD_CONST;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_TX_WAIT:    if (!tx_busy_i) next_state = ST_TRANSMIT;
            ST_TRANSMIT:   next_state = enable_i ? ST_LOAD_CONST : ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase

        // SAVE is only ever entered from WAIT_HASH, so better_i is read on the done edge.
        case (next_state)
            ST_LOAD_CONST: cmd_next = CMD_CONST_OE;
            ST_LOAD_NONCE: cmd_next = CMD_NONCE_OE;
            ST_SAVE:       cmd_next = better_i ? CMD_SAVE_BEST : CMD_NOP;
            ST_INCREMENT:  cmd_next = CMD_INC_NONCE;
            ST_TRANSMIT:   cmd_next = CMD_TRANSMIT;
            default:       cmd_next = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            global_command_o <= CMD_NOP;
            hash_start_o     <= 1'b0;
            busy_o           <= 1'b0;
            hash_count_o     <= '0;
            tx_due           <= 1'b0;
            tx_latch         <= 1'b0;
        end else begin
            global_command_o <= cmd_next;
            hash_start_o     <= (next_state == ST_START);
            busy_o           <= (next_state != ST_IDLE);
            if (entering_increment) begin
                hash_count_o <= hash_count_o + 32'd1;
                tx_due       <= interval_wrap;
            end
            // A request arriving on the same edge as the clear survives it.
            tx_latch <= transmit_req_i || (tx_latch && (next_state != ST_TRANSMIT));
        end
    end

endmodule

// File: tb/tb_global_command_sequencer.sv
// Bench for global_command_sequencer: procedural behavioural model plus directed and random stimulus.
module tb_global_command_sequencer;

    localparam int unsigned L_CYC = 4;
    localparam int unsigned T_INT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        hash_done = 1'b0;
    logic        better = 1'b0;
    logic        transmit_req = 1'b0;
    logic        tx_busy = 1'b0;
    logic        hash_start_o;
    logic [2:0]  global_command_o;
    logic        busy_o;
    logic [31:0] hash_count_o;

    global_command_sequencer #(
        .LOAD_CYCLES       (L_CYC),
        .TRANSMIT_INTERVAL (T_INT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .hash_done_i      (hash_done),
        .better_i         (better),
        .transmit_req_i   (transmit_req),
        .tx_busy_i        (tx_busy),
        .hash_start_o     (hash_start_o),
        .global_command_o (global_command_o),
        .busy_o           (busy_o),
        .hash_count_o     (hash_count_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit auto_core = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]  exp_cmd = 3'd0;
    logic        exp_start = 1'b0;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_count = 32'd0;
    bit          m_abort;
    bit          m_latch = 1'b0;
    int unsigned m_interval = 0;
    logic s_en, s_done, s_better, s_req, s_txb;

    task automatic tick();
        @(posedge clk);
        s_en = enable; s_done = hash_done; s_better = better;
        s_req = transmit_req; s_txb = tx_busy;
        if (rst) begin
            m_abort = 1'b1; m_latch = 1'b0; m_interval = 0;
            exp_cmd = 3'd0; exp_start = 1'b0; exp_busy = 1'b0; exp_count = 32'd0;
        end else if (s_req) begin
            m_latch = 1'b1;
        end
    endtask

    task automatic step(input logic [2:0] c, input logic st);
        tick();
        if (!m_abort) begin
            exp_cmd = c; exp_start = st; exp_busy = 1'b1;
        end
    endtask

    // Called right after the edge that starts a nonce; returns whether another nonce follows.
    task automatic run_nonce(output bit cont);
        bit tx;
        cont = 1'b0;
        exp_cmd = 3'd4; exp_start = 1'b0; exp_busy = 1'b1;
        for (int i = 1; i < int'(L_CYC); i++) begin step(3'd4, 1'b0); if (m_abort) return; end
        for (int i = 0; i < int'(L_CYC); i++) begin step(3'd5, 1'b0); if (m_abort) return; end
        step(3'd0, 1'b1); if (m_abort) return;
        step(3'd0, 1'b0); if (m_abort) return;
        do begin tick(); if (m_abort) return; end while (!s_done);
        exp_cmd = s_better ? 3'd2 : 3'd0;
        step(3'd1, 1'b0); if (m_abort) return;
        exp_count = exp_count + 32'd1;
        m_interval = (m_interval + 1) % T_INT;
        tx = (m_interval == 0) || m_latch;
        if (tx) begin
            step(3'd0, 1'b0); if (m_abort) return;
            do begin tick(); if (m_abort) return; end while (s_txb);
            exp_cmd = 3'd3;
            m_latch = s_req;
        end
        tick(); if (m_abort) return;
        cont = s_en;
        if (!cont) begin
            exp_cmd = 3'd0; exp_start = 1'b0; exp_busy = 1'b0;
        end
    endtask

    initial begin
        bit cont;
        forever begin
            m_abort = 1'b0;
            tick();
            if (m_abort) continue;
            if (s_en) begin
                cont = 1'b1;
                while (cont && !m_abort) run_nonce(cont);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd", 32'(global_command_o), 32'(exp_cmd));
            chk("start", 32'(hash_start_o), 32'(exp_start));
            chk("busy", 32'(busy_o), 32'(exp_busy));
            chk("count", hash_count_o, exp_count);
        end
    end

    // Skein core stand-in: answers each start pulse after a random latency.
    initial begin
        int core_wait = 0;
        forever begin
            @(negedge clk);
            if (auto_core) begin
                if (core_wait > 0) begin
                    core_wait--;
                    if (core_wait == 0) begin
                        hash_done = 1'b1;
                        better = 1'($urandom % 2);
                    end
                end else begin
                    hash_done = 1'b0;
                    if (hash_start_o) core_wait = int'($urandom_range(1, 5));
                end
            end else begin
                core_wait = 0;
            end
        end
    end

    task automatic wait_cmd(input logic [2:0] c, input string nm);
        int n = 0;
        while (global_command_o !== c && n < 300) begin @(negedge clk); n++; end
        chk(nm, 32'(global_command_o === c), 32'd1);
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (hash_start_o !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk(nm, 32'(hash_start_o === 1'b1), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy_o !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        chk(nm, 32'(busy_o), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tx_n;
        logic [31:0] tx_at [2];
        int n;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_cmd", 32'(global_command_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_count", hash_count_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Load phase timing
        enable = 1'b1;
        for (int i = 0; i < 2 * int'(L_CYC); i++) begin
            @(negedge clk);
            chk("t1_load_cmd", 32'(global_command_o), (i < int'(L_CYC)) ? 32'd4 : 32'd5);
            chk("t1_no_start", 32'(hash_start_o), 32'd0);
        end
        @(negedge clk);
        chk("t1_start", 32'(hash_start_o), 32'd1);
        repeat (3) begin @(negedge clk); chk("t1_wait_cmd", 32'(global_command_o), 32'd0); end

        // Better hash, then not better; a done during START is ignored
        hash_done = 1'b1; better = 1'b1;
        @(negedge clk); hash_done = 1'b0; better = 1'b0;
        chk("t2_save_best", 32'(global_command_o), 32'd2);
        @(negedge clk);
        chk("t2_inc", 32'(global_command_o), 32'd1);
        chk("t2_count1", hash_count_o, 32'd1);
        wait_start("t2_start2");
        hash_done = 1'b1;
        @(negedge clk); hash_done = 1'b0;
        @(negedge clk);
        chk("t2_done_in_start_ignored", 32'(global_command_o), 32'd0);
        hash_done = 1'b1; better = 1'b0;
        @(negedge clk); hash_done = 1'b0;
        chk("t2_save_nop", 32'(global_command_o), 32'd0);
        @(negedge clk);
        chk("t2_inc2", 32'(global_command_o), 32'd1);
        chk("t2_count2", hash_count_o, 32'd2);

        // Reset in WAIT_HASH
        wait_start("t5_start");
        repeat (2) @(negedge clk);
        rst = 1'b1; enable = 1'b0;
        @(negedge clk); rst = 1'b0;
        chk("t5_rst_cmd", 32'(global_command_o), 32'd0);
        chk("t5_rst_busy", 32'(busy_o), 32'd0);
        chk("t5_rst_count", hash_count_o, 32'd0);

        // Interval transmits over 8 nonces
        auto_core = 1'b1; tx_busy = 1'b0; enable = 1'b1;
        tx_n = 0; tx_at[0] = '0; tx_at[1] = '0; n = 0;
        while (n < 2000 && !(tx_n >= 2 && busy_o == 1'b0)) begin
            @(negedge clk); n++;
            if (global_command_o == 3'd3) begin
                if (tx_n < 2) tx_at[tx_n] = hash_count_o;
                tx_n++;
            end
            if (hash_count_o == 32'd8 && global_command_o == 3'd1) enable = 1'b0;
        end
        chk("t3_tx_count", 32'(tx_n), 32'd2);
        chk("t3_tx_after_4", tx_at[0], 32'd4);
        chk("t3_tx_after_8", tx_at[1], 32'd8);

        // Host request while hashing, transmitter busy for 10 cycles
        auto_core = 1'b0; hash_done = 1'b0; enable = 1'b1;
        wait_start("t4_start");
        @(negedge clk); transmit_req = 1'b1;
        @(negedge clk); transmit_req = 1'b0; tx_busy = 1'b1;
        @(negedge clk); hash_done = 1'b1; better = 1'b0;
        @(negedge clk); hash_done = 1'b0;
        wait_cmd(3'd1, "t4_inc");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_txwait_hold", 32'(global_command_o), 32'd0);
            chk("t4_txwait_busy", 32'(busy_o), 32'd1);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        chk("t4_transmit", 32'(global_command_o), 32'd3);
        @(negedge clk);
        chk("t4_idle", 32'(busy_o), 32'd0);

        // Drop enable during LOAD_NONCE
        auto_core = 1'b1; enable = 1'b1;
        wait_cmd(3'd5, "t5_load_nonce");
        enable = 1'b0;
        wait_cmd(3'd1, "t5_finish_inc");
        @(negedge clk);
        chk("t5_idle_busy", 32'(busy_o), 32'd0);
        chk("t5_idle_cmd", 32'(global_command_o), 32'd0);

        // Count wrap and stray done in IDLE
        auto_core = 1'b0;
        @(posedge clk); #2;
        force dut.hash_count_o = 32'hFFFF_FFFF;
        exp_count = 32'hFFFF_FFFF;
        #1 release dut.hash_count_o;
        @(negedge clk);
        chk("t6_preload", hash_count_o, 32'hFFFF_FFFF);
        hash_done = 1'b1;
        @(negedge clk); hash_done = 1'b0;
        @(negedge clk);
        chk("t6_done_idle_busy", 32'(busy_o), 32'd0);
        chk("t6_done_idle_cmd", 32'(global_command_o), 32'd0);
        auto_core = 1'b1; enable = 1'b1;
        wait_cmd(3'd5, "t6_load_nonce");
        enable = 1'b0;
        wait_cmd(3'd1, "t6_inc");
        chk("t6_count_wrap", hash_count_o, 32'd0);
        wait_idle("t6_idle");

        // Random traffic
        auto_core = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5000; i++) begin
            hash_done    = ($urandom % 8) == 0;
            better       = 1'($urandom % 2);
            tx_busy      = ($urandom % 3) == 0;
            transmit_req = ($urandom % 40) == 0;
            rst          = ($urandom % 1500) == 0;
            if (($urandom % 60) == 0) enable = ~enable;
            @(negedge clk);
        end
        enable = 1'b0; rst = 1'b0; transmit_req = 1'b0; tx_busy = 1'b0;
        n = 0;
        while (busy_o !== 1'b0 && n < 400) begin
            hash_done = ($urandom % 4) == 0;
            @(negedge clk); n++;
        end
        hash_done = 1'b0;
        chk("drain_idle", 32'(busy_o), 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
